// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one word load/store at a time, holds it for
// LATENCY clock edges, then presents a response until the CPU consumes it.
module dmem_responder #(
    parameter int unsigned MEM_DEPTH = 16384,
    parameter int unsigned LATENCY   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int unsigned IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [7:0]  cnt;
    logic        lat_write;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;

    logic [31:0] mem [MEM_DEPTH];

    // Request seen at the commit edge: with LATENCY=1 the commit coincides
    // with acceptance, so the live request is used instead of the latched one.
    logic             commit;
    logic             c_write;
    logic [31:0]      c_addr;
    logic [31:0]      c_wdata;
    logic             c_err;
    logic [IDX_W-1:0] c_idx;

    // Control outputs are decoded from state only.
    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);

    // Next-state decode.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (req_valid) state_next = (LATENCY == 1) ? RESP : WAIT;
            WAIT: if (cnt == 8'd1) state_next = RESP;
            RESP: if (resp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Commit-edge request selection and error check.
    always_comb begin
        commit  = (state_next == RESP) && (state != RESP);
        c_write = (state == IDLE) ? req_write : lat_write;
        c_addr  = (state == IDLE) ? req_addr  : lat_addr;
        c_wdata = (state == IDLE) ? req_wdata : lat_wdata;
        c_err   = (c_addr[1:0] != 2'b00) || ({2'b00, c_addr[31:2]} >= MEM_DEPTH);
        c_idx   = c_addr[IDX_W+1:2];
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Request latch, latency counter and response registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt        <= '0;
            lat_write  <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            if (state == IDLE && req_valid) begin
                lat_write <= req_write;
                lat_addr  <= req_addr;
                lat_wdata <= req_wdata;
                cnt       <= 8'(LATENCY - 1);
            end else if (state == WAIT) begin
                cnt <= cnt - 8'd1;
            end
            if (commit) begin
                resp_err   <= c_err;
                resp_rdata <= (!c_err && !c_write) ? mem[c_idx] : '0;
            end
        end
    end

    // Storage array; contents survive reset, stores land only on a legal commit.
    always_ff @(posedge clk) begin
        if (!reset && commit && c_write && !c_err) mem[c_idx] <= c_wdata;
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a LATENCY=4 instance for the main
// transaction/error/backpressure/reset cases and a LATENCY=1 instance for
// back-to-back throughput.
module tb_dmem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // LATENCY=4 instance signals
    logic        reset, req_valid, req_ready, req_write, resp_valid, resp_ready, resp_err;
    logic [31:0] req_addr, req_wdata, resp_rdata;
    // LATENCY=1 instance signals
    logic        reset1, req_valid1, req_ready1, req_write1, resp_valid1, resp_ready1, resp_err1;
    logic [31:0] req_addr1, req_wdata1, resp_rdata1;

    int vectors = 0;
    int miscompares = 0;

    dmem_responder #(.MEM_DEPTH(16384), .LATENCY(4)) u_dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    dmem_responder #(.MEM_DEPTH(16384), .LATENCY(1)) u_dut1 (
        .clk(clk), .reset(reset1), .req_valid(req_valid1), .req_ready(req_ready1),
        .req_write(req_write1), .req_addr(req_addr1), .req_wdata(req_wdata1),
        .resp_valid(resp_valid1), .resp_ready(resp_ready1),
        .resp_rdata(resp_rdata1), .resp_err(resp_err1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One transaction on the LATENCY=4 instance; hold = cycles of resp_ready=0
    // after resp_valid rises.
    task automatic txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] rdata_exp, input logic err_exp, input int hold);
        int n;
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wdata;
        resp_ready = 1'b0;
        chk("req_ready_before_accept", req_ready, 1);
        tick();
        req_valid = 1'b0;
        chk("req_ready_after_accept", req_ready, 0);
        n = 1;
        while (!resp_valid && n < 20) begin
            tick();
            n++;
        end
        chk("latency_edges", n, 4);
        chk("resp_rdata", resp_rdata, rdata_exp);
        chk("resp_err", resp_err, err_exp);
        chk("req_ready_in_resp", req_ready, 0);
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("hold_resp_valid", resp_valid, 1);
            chk("hold_resp_rdata", resp_rdata, rdata_exp);
            chk("hold_resp_err", resp_err, err_exp);
            chk("hold_req_ready", req_ready, 0);
        end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        chk("req_ready_after_handshake", req_ready, 1);
        chk("resp_valid_after_handshake", resp_valid, 0);
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        resp_ready = 1'b0;
        reset1 = 1'b1; req_valid1 = 1'b0; req_write1 = 1'b0; req_addr1 = '0; req_wdata1 = '0;
        resp_ready1 = 1'b1;
        tick();
        tick();
        chk("reset_req_ready", req_ready, 1);
        chk("reset_resp_valid", resp_valid, 0);
        chk("reset_resp_rdata", resp_rdata, 0);
        chk("reset_resp_err", resp_err, 0);
        reset = 1'b0;
        reset1 = 1'b0;
        tick();

        // Store then load back
        txn(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, 1'b0, 0);
        txn(1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 1'b0, 0);
        // Misaligned store is rejected and leaves memory alone
        txn(1'b1, 32'h0000_0012, 32'h1234_5678, 32'h0, 1'b1, 0);
        txn(1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 1'b0, 0);
        // Out-of-range load (word index 16384)
        txn(1'b0, 32'h0001_0000, 32'h0, 32'h0, 1'b1, 0);
        // Last legal word round trip
        txn(1'b1, 32'h0000_FFFC, 32'h0BAD_CAFE, 32'h0, 1'b0, 0);
        txn(1'b0, 32'h0000_FFFC, 32'h0, 32'h0BAD_CAFE, 1'b0, 0);
        // Backpressure: resp_ready low for 6 cycles
        txn(1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 1'b0, 6);

        // Reset mid-WAIT discards a pending store
        txn(1'b1, 32'h0000_0020, 32'h1111_2222, 32'h0, 1'b0, 0);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h0000_0020; req_wdata = 32'hCAFE_F00D;
        tick();
        req_valid = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midwait_reset_req_ready", req_ready, 1);
        chk("midwait_reset_resp_valid", resp_valid, 0);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("midwait_no_resp", resp_valid, 0);
        end
        txn(1'b0, 32'h0000_0020, 32'h0, 32'h1111_2222, 1'b0, 0);

        // LATENCY=1 back-to-back stores with req_valid held high
        req_valid1 = 1'b1; req_write1 = 1'b1; req_addr1 = 32'h0000_0040; req_wdata1 = 32'hA5A5_0001;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("b2b_resp_valid", resp_valid1, (i % 2 == 0) ? 1 : 0);
            chk("b2b_req_ready", req_ready1, (i % 2 == 1) ? 1 : 0);
            if (i % 2 == 0) begin
                chk("b2b_resp_err", resp_err1, 0);
                // Misaligned request presented during RESP must be ignored
                req_addr1 = 32'h0000_0041;
            end else begin
                req_addr1 = 32'h0000_0040;
            end
        end
        req_write1 = 1'b0;
        tick();
        req_valid1 = 1'b0;
        chk("lat1_load_resp_valid", resp_valid1, 1);
        chk("lat1_load_rdata", resp_rdata1, 32'hA5A5_0001);
        chk("lat1_load_err", resp_err1, 0);
        tick();
        chk("lat1_idle_req_ready", req_ready1, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
